// File: rtl/decode_regfile_sb.sv
// -----------------------------------------------------------------------------
// decode_regfile_sb
//
// Register file with an integrated scoreboard for the decode stage.
// Two combinational read ports, one writeback port, and one busy bit per
// register that marks a value still being produced by an in-flight
// instruction. A stall is raised when the instruction in decode reads or
// overwrites a register whose value is still pending.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   When defined, a writeback forwards its data to a same-cycle read of the
//   same register and clears that read's hazard in the same cycle. When
//   undefined, reads see the pre-write value and the hazard clears one cycle
//   after the writeback.
//
// Parameters:
//   NUM_REGISTERS      number of architectural registers
//   LOG_NUM_REGISTERS  address width, clog2(NUM_REGISTERS)
//   WIDTH              data width
//   ZERO_REG           1 = register 0 reads 0, ignores writes, never busy
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   ra, rb             read addresses; ra_en/rb_en say the operand is used
//   a, b               read data (combinational)
//   issue_valid        decode wants to issue this cycle
//   issue_we/dst       issuing instruction writes register issue_dst
//   issue_ack          issue accepted (issue_valid && !stall)
//   stall              hazard, decode must hold
//   writeEnable/Addr,d writeback port
//   busy               per-register pending bits
// -----------------------------------------------------------------------------
module decode_regfile_sb #(
  parameter int NUM_REGISTERS     = 8,
  parameter int LOG_NUM_REGISTERS = 3,
  parameter int WIDTH             = 16,
  parameter int ZERO_REG          = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LOG_NUM_REGISTERS-1:0] ra,
  input  logic [LOG_NUM_REGISTERS-1:0] rb,
  input  logic                         ra_en,
  input  logic                         rb_en,
  output logic [WIDTH-1:0]             a,
  output logic [WIDTH-1:0]             b,
  input  logic                         issue_valid,
  input  logic                         issue_we,
  input  logic [LOG_NUM_REGISTERS-1:0] issue_dst,
  output logic                         issue_ack,
  output logic                         stall,
  input  logic                         writeEnable,
  input  logic [LOG_NUM_REGISTERS-1:0] writeAddr,
  input  logic [WIDTH-1:0]             d,
  output logic [NUM_REGISTERS-1:0]     busy
);

  logic [WIDTH-1:0]         regs_q [NUM_REGISTERS];
  logic [WIDTH-1:0]         regs_d [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] busy_q;
  logic [NUM_REGISTERS-1:0] busy_d;

  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic             fwd_a;
  logic             fwd_b;
  logic             haz_a;
  logic             haz_b;
  logic             haz_w;
  logic             stall_int;
  logic             ack_int;
  logic             wb_ok;

  // Addresses beyond NUM_REGISTERS exist only when it is not a power of two.
  function automatic logic in_range(input logic [LOG_NUM_REGISTERS-1:0] addr);
    return (int'(addr) < NUM_REGISTERS);
  endfunction

  function automatic logic is_zero_reg(input logic [LOG_NUM_REGISTERS-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  function automatic logic writable(input logic [LOG_NUM_REGISTERS-1:0] addr);
    return in_range(addr) && !is_zero_reg(addr);
  endfunction

  function automatic logic bit_at(input logic [NUM_REGISTERS-1:0]     v,
                                  input logic [LOG_NUM_REGISTERS-1:0] addr);
    logic r;
    r = 1'b0;
    if (in_range(addr)) r = v[addr];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Read ports and optional writeback forwarding
  // ---------------------------------------------------------------------------
  always_comb begin
    a_val = '0;
    b_val = '0;
    if (in_range(ra)) a_val = regs_q[ra];
    if (in_range(rb)) b_val = regs_q[rb];
`ifdef REGFILE_BYPASS_EN
    fwd_a = writeEnable && in_range(ra) && (writeAddr == ra);
    fwd_b = writeEnable && in_range(rb) && (writeAddr == rb);
    if (fwd_a) a_val = d;
    if (fwd_b) b_val = d;
`else
    fwd_a = 1'b0;
    fwd_b = 1'b0;
`endif
    // Zero-register masking wins over forwarding.
    if (is_zero_reg(ra)) a_val = '0;
    if (is_zero_reg(rb)) b_val = '0;
  end

  assign a = a_val;
  assign b = b_val;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    haz_a     = ra_en && bit_at(busy_q, ra) && !fwd_a;
    haz_b     = rb_en && bit_at(busy_q, rb) && !fwd_b;
    // A writeback landing on the destination this cycle retires the old
    // producer, so the new one may issue even without forwarding.
    haz_w     = issue_we && bit_at(busy_q, issue_dst)
                && !(writeEnable && (writeAddr == issue_dst));
    stall_int = issue_valid && (haz_a || haz_b || haz_w);
    ack_int   = issue_valid && !stall_int;
  end

  assign stall     = stall_int;
  assign issue_ack = ack_int;

  // ---------------------------------------------------------------------------
  // Next-state: register contents and scoreboard
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_ok  = writeEnable && writable(writeAddr);
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_ok) begin
      regs_d[writeAddr] = d;
      busy_d[writeAddr] = 1'b0;
    end
    // Set after clear: a new producer issued in the writeback cycle of the
    // old one leaves the register pending.
    if (ack_int && issue_we && writable(issue_dst)) busy_d[issue_dst] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGISTERS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_decode_regfile_sb.sv
module tb_decode_regfile_sb;
  localparam int N = 8;
  localparam int L = 3;
  localparam int W = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [L-1:0] ra, rb, issue_dst, writeAddr;
  logic         ra_en, rb_en, issue_valid, issue_we, writeEnable;
  logic [W-1:0] d, a, b;
  logic         issue_ack, stall;
  logic [N-1:0] busy;

  int checks = 0;
  int failures = 0;

  decode_regfile_sb #(
    .NUM_REGISTERS(N), .LOG_NUM_REGISTERS(L), .WIDTH(W), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset),
    .ra(ra), .rb(rb), .ra_en(ra_en), .rb_en(rb_en), .a(a), .b(b),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst),
    .issue_ack(issue_ack), .stall(stall),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .d(d), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: architectural values and pending flags.
  int m_regs [N];
  bit m_busy [N];

  function automatic int m_read(input int r);
    if (r == 0) return 0;
    if (BYP && writeEnable && int'(writeAddr) == r) return int'(d);
    return m_regs[r];
  endfunction

  function automatic bit m_stall();
    bit h;
    h = 1'b0;
    if (ra_en && m_busy[ra] && !(BYP && writeEnable && writeAddr == ra)) h = 1'b1;
    if (rb_en && m_busy[rb] && !(BYP && writeEnable && writeAddr == rb)) h = 1'b1;
    if (issue_we && m_busy[issue_dst] && !(writeEnable && writeAddr == issue_dst)) h = 1'b1;
    return issue_valid && h;
  endfunction

  function automatic int m_busy_vec();
    int v;
    v = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) v += (1 << i);
    return v;
  endfunction

  task automatic m_edge();
    bit ack;
    ack = issue_valid && !m_stall();
    if (writeEnable && writeAddr != 0) begin
      m_regs[writeAddr] = int'(d);
      m_busy[writeAddr] = 1'b0;
    end
    if (ack && issue_we && issue_dst != 0) m_busy[issue_dst] = 1'b1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = 0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] i_ra, input logic [2:0] i_rb,
                        input logic i_ra_en, input logic i_rb_en,
                        input logic i_iv, input logic i_iwe, input logic [2:0] i_dst,
                        input logic i_we, input logic [2:0] i_wa, input logic [15:0] i_d);
    ra = i_ra; rb = i_rb; ra_en = i_ra_en; rb_en = i_rb_en;
    issue_valid = i_iv; issue_we = i_iwe; issue_dst = i_dst;
    writeEnable = i_we; writeAddr = i_wa; d = i_d;
  endtask

  // Clock edge with model update; returns 1 time unit after the edge.
  task automatic do_edge();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  typedef struct {
    logic [2:0]  ra, rb;
    logic        ra_en, rb_en, iv, iwe;
    logic [2:0]  dst;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] d;
    logic [15:0] ea, eb;
    logic        es, eack;
    logic [7:0]  ebusy;
  } vec_t;

  vec_t tbl [16];

  initial begin
    //          ra rb ren ben iv iwe dst we wa d         ea        eb        es ack busy
    tbl[0]  = '{1, 3, 0, 0, 0, 0, 0, 1, 5, 16'hBEEF, 16'h0000, 16'h0000, 0, 0, 8'h00};
    tbl[1]  = '{5, 0, 0, 0, 0, 0, 0, 1, 0, 16'hFFFF, 16'hBEEF, 16'h0000, 0, 0, 8'h00};
    tbl[2]  = '{0, 5, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 8'h00};
    tbl[3]  = '{5, 0, 1, 0, 1, 1, 2, 0, 0, 16'h0000, 16'hBEEF, 16'h0000, 0, 1, 8'h00};
    tbl[4]  = '{2, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 8'h04};
    tbl[5]  = '{0, 0, 0, 0, 1, 1, 4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 8'h04};
    tbl[6]  = '{0, 0, 0, 0, 1, 1, 4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 8'h14};
    tbl[7]  = '{0, 0, 0, 0, 1, 1, 4, 1, 4, 16'h0444, 16'h0000, 16'h0000, 0, 1, 8'h14};
    tbl[8]  = '{4, 2, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0444, 16'h0000, 0, 0, 8'h14};
    tbl[9]  = '{0, 0, 0, 0, 1, 1, 6, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 8'h14};
    tbl[10] = '{6, 6, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 8'h54};
    tbl[11] = '{0, 0, 0, 0, 1, 1, 1, 1, 4, 16'h1111, 16'h0000, 16'h0000, 0, 1, 8'h54};
    tbl[12] = '{4, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h1111, 16'h0000, 0, 0, 8'h46};
    tbl[13] = '{1, 7, 0, 0, 0, 0, 0, 1, 6, 16'h0066, 16'h0000, 16'h0000, 0, 0, 8'h46};
    tbl[14] = '{6, 0, 1, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0066, 16'h0000, 0, 1, 8'h06};
    tbl[15] = '{2, 6, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0066, 0, 0, 8'h06};

    // Reset
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_a", int'(a), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_stall", int'(stall), 0);
    do_edge();

    // Directed table
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].ra, tbl[i].rb, tbl[i].ra_en, tbl[i].rb_en, tbl[i].iv, tbl[i].iwe,
             tbl[i].dst, tbl[i].we, tbl[i].wa, tbl[i].d);
      @(negedge clk);
      chk($sformatf("tbl%0d_a", i), int'(a), int'(tbl[i].ea));
      chk($sformatf("tbl%0d_b", i), int'(b), int'(tbl[i].eb));
      chk($sformatf("tbl%0d_stall", i), int'(stall), int'(tbl[i].es));
      chk($sformatf("tbl%0d_ack", i), int'(issue_ack), int'(tbl[i].eack));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].ebusy));
      do_edge();
    end

    // RAW hazard across a writeback
    set_in(0, 0, 0, 0, 1, 1, 3, 0, 0, 16'h0);
    @(negedge clk);
    chk("raw_issue_ack", int'(issue_ack), 1);
    do_edge();
    set_in(3, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0);
    @(negedge clk);
    chk("raw_stall", int'(stall), 1);
    chk("raw_ack", int'(issue_ack), 0);
    do_edge();
    set_in(3, 0, 1, 0, 1, 0, 0, 1, 3, 16'h0042);
    @(negedge clk);
    chk("raw_wb_stall", int'(stall), BYP ? 0 : 1);
    chk("raw_wb_a", int'(a), BYP ? 'h42 : 0);
    do_edge();
    set_in(3, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0);
    @(negedge clk);
    chk("raw_after_stall", int'(stall), 0);
    chk("raw_after_a", int'(a), 'h42);
    chk("raw_after_busy3", int'(busy[3]), 0);
    do_edge();

    // Asynchronous reset in mid-cycle
    set_in(0, 0, 0, 0, 1, 1, 5, 1, 3, 16'h1234);
    do_edge();
    set_in(3, 5, 1, 1, 1, 0, 0, 0, 0, 16'h0);
    @(negedge clk);
    chk("pre_rst_a", int'(a), 'h1234);
    chk("pre_rst_stall", int'(stall), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_a", int'(a), 0);
    chk("rst_b", int'(b), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_ack", int'(issue_ack), 1);
    #1 reset = 1'b0;
    m_reset();
    do_edge();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 3, 16'h7777);
    do_edge();
    set_in(3, 5, 1, 1, 1, 1, 5, 0, 0, 16'h0);
    @(negedge clk);
    chk("post_rst_a", int'(a), 'h7777);
    chk("post_rst_stall", int'(stall), 0);
    do_edge();

    // Randomized against the model
    for (int n = 0; n < 400; n++) begin
      set_in(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 9) < 6), 1'($urandom), 3'($urandom),
             ($urandom_range(0, 9) < 4), 3'($urandom), 16'($urandom));
      @(negedge clk);
      chk("rnd_a", int'(a), m_read(int'(ra)));
      chk("rnd_b", int'(b), m_read(int'(rb)));
      chk("rnd_stall", int'(stall), int'(m_stall()));
      chk("rnd_ack", int'(issue_ack), int'(issue_valid && !m_stall()));
      chk("rnd_busy", int'(busy), m_busy_vec());
      do_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
